sum_engine: RTL and testbench

SUM_ENGINE -- requirements
Module: sum_engine

---
 rtl/sum_engine.sv | 176 +++++++++++++++++
 tb/tb_sum_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sum_engine.sv
// sum_engine: multi-cycle summation controller plus datapath.
// Computes step + 2*step + 3*step + ... over all terms <= limit, modulo
// 2^WIDTH, and flags whether the result wrapped. A six-state controller
// (IDLE, INIT, CHECK, ADD, OUT, DONE) sequences a small accumulator datapath.
// The controller decodes one-cycle strobes that tell the datapath what to do
// on the next rising edge.

module sum_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] step,
    output logic [WIDTH-1:0] outPort,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    // The accumulator add must cover whichever of the sum and the term is
    // wider, plus one bit so that a carry out of the WIDTH-bit sum is visible.
    localparam int SUM_W = ((WIDTH > CNT_W) ? WIDTH : CNT_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CHECK,
        ADD,
        OUT,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Operands captured when a request is accepted, so input changes during
    // a run have no effect on it.
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] step_q;

    // Loop state: i is the most recently added term, sum the running total.
    logic [CNT_W-1:0] i_q;
    logic [WIDTH-1:0] sum_q;
    logic             wrap_q;

    // Controller strobes, decoded from the current state.
    logic accept;
    logic clear_loop;
    logic do_add;
    logic load_result;

    // Datapath combinational results.
    logic [CNT_W:0]   i_next;
    logic             more_terms;
    logic [SUM_W-1:0] sum_ext;
    logic             sum_carry;

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------

    // Next term and its bound check, one bit wider than the counter so the
    // candidate term can never wrap back under the limit.
    always_comb begin
        i_next     = {1'b0, i_q} + {1'b0, step_q};
        more_terms = (i_next <= {1'b0, limit_q});
    end

    // Accumulate the next term with enough headroom to see the carry out.
    always_comb begin
        sum_ext   = SUM_W'(sum_q) + SUM_W'(i_next);
        sum_carry = |sum_ext[SUM_W-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // Controller: state register / next state / outputs
    // ------------------------------------------------------------------

    // State register; reset returns the controller to IDLE at once.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT:    state_d = CHECK;
            CHECK:   state_d = more_terms ? ADD : OUT;
            ADD:     state_d = CHECK;
            OUT:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs and datapath strobes decoded from the current state.
    always_comb begin
        busy        = 1'b1;
        done        = 1'b0;
        accept      = 1'b0;
        clear_loop  = 1'b0;
        do_add      = 1'b0;
        load_result = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy   = 1'b0;
                accept = start;
            end
            INIT:    clear_loop  = 1'b1;
            CHECK:   ;
            ADD:     do_add      = 1'b1;
            OUT:     load_result = 1'b1;
            DONE:    done        = 1'b1;
            default: busy        = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Capture the request operands; a zero step would never terminate, so
    // it is replaced by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            limit_q <= '0;
            step_q  <= '0;
        end else if (accept) begin
            limit_q <= limit;
            step_q  <= (step == '0) ? CNT_W'(1) : step;
        end
    end

    // Loop counter, running sum and sticky wrap flag for the current run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_q    <= '0;
            sum_q  <= '0;
            wrap_q <= 1'b0;
        end else if (clear_loop) begin
            i_q    <= '0;
            sum_q  <= '0;
            wrap_q <= 1'b0;
        end else if (do_add) begin
            // i_next fits in CNT_W bits here because it passed the bound check.
            i_q    <= i_next[CNT_W-1:0];
            sum_q  <= sum_ext[WIDTH-1:0];
            wrap_q <= wrap_q | sum_carry;
        end
    end

    // Published result; holds from one OUT edge to the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outPort  <= '0;
            overflow <= 1'b0;
        end else if (load_result) begin
            outPort  <= sum_q;
            overflow <= wrap_q;
        end
    end

endmodule

// File: tb/tb_sum_engine.sv
// tb_sum_engine: directed self-checking bench for sum_engine (WIDTH=8,
// CNT_W=8). Expected results and edge counts are hand-computed constants.

module tb_sum_engine;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] limit;
    logic [7:0] step;
    logic [7:0] outPort;
    logic       busy;
    logic       done;
    logic       overflow;

    int n_compared;
    int n_mismatched;

    sum_engine #(
        .WIDTH(8),
        .CNT_W(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .limit   (limit),
        .step    (step),
        .outPort (outPort),
        .busy    (busy),
        .done    (done),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Issue one request, scramble the inputs while busy, then wait (bounded)
    // for done and check latency, result, and return to IDLE.
    task automatic run(input string tag, input logic [7:0] l, input logic [7:0] s,
                       input logic [7:0] exp_out, input logic exp_ovf,
                       input int exp_edges);
        int edges;
        start = 1'b1;
        limit = l;
        step  = s;
        tick();
        start = 1'b0;
        limit = 8'($urandom);
        step  = 8'($urandom);
        check({tag, " busy"}, 32'(busy), 32'd1);
        edges = 0;
        while (!done && edges < 300) begin
            tick();
            edges++;
        end
        check({tag, " edges"}, 32'(edges), 32'(exp_edges));
        check({tag, " outPort"}, 32'(outPort), 32'(exp_out));
        check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        tick();
        check({tag, " done width"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    int done_cnt;
    int first_done;
    int second_done;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst   = 1'b0;
        start = 1'b0;
        limit = 8'd0;
        step  = 8'd0;

        // Reset state.
        #1;
        check("rst outPort", 32'(outPort), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Main function: 1..10, 3+6+9, wrapping 1..30, then 1..4.
        run("sum10", 8'd10, 8'd1, 8'd55, 1'b0, 23);
        run("step3", 8'd10, 8'd3, 8'd18, 1'b0, 9);
        run("wrap30", 8'd30, 8'd1, 8'd209, 1'b1, 63);

        // Result holds while idle.
        repeat (3) tick();
        check("hold outPort", 32'(outPort), 32'd209);
        check("hold overflow", 32'(overflow), 32'd1);

        run("after wrap", 8'd4, 8'd1, 8'd10, 1'b0, 11);

        // Boundaries: limit 0, step 0 -> 1, limit below step.
        run("limit0", 8'd0, 8'd1, 8'd0, 1'b0, 3);
        run("step0", 8'd3, 8'd0, 8'd6, 1'b0, 9);
        run("limit<step", 8'd5, 8'd7, 8'd0, 1'b0, 3);

        // Back-to-back: start held high re-accepts on the first IDLE edge.
        start = 1'b1;
        limit = 8'd0;
        step  = 8'd1;
        tick();
        first_done  = 0;
        second_done = 0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (done) begin
                if (first_done == 0) first_done = e;
                else second_done = e;
            end
        end
        start = 1'b0;
        check("b2b first done", 32'(first_done), 32'd3);
        check("b2b second done", 32'(second_done), 32'd8);

        // Start pulsed and operands changed mid-run, and start during DONE.
        start = 1'b1;
        limit = 8'd10;
        step  = 8'd1;
        tick();
        start = 1'b0;
        done_cnt   = 0;
        first_done = 0;
        for (int e = 1; e <= 26; e++) begin
            if (e == 5) begin
                start = 1'b1;
                limit = 8'd3;
                step  = 8'd2;
            end
            if (e == 6)  start = 1'b0;
            if (e == 24) start = 1'b1;
            if (e == 25) start = 1'b0;
            tick();
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = e;
            end
        end
        check("midrun done count", 32'(done_cnt), 32'd1);
        check("midrun done edge", 32'(first_done), 32'd23);
        check("midrun outPort", 32'(outPort), 32'd55);
        check("start in DONE ignored", 32'(busy), 32'd0);

        // Reset asserted while in ADD aborts the run immediately.
        start = 1'b1;
        limit = 8'd10;
        step  = 8'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort outPort", 32'(outPort), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort overflow", 32'(overflow), 32'd0);
        done_cnt = 0;
        repeat (3) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort no done", 32'(done_cnt), 32'd0);
        rst = 1'b1;

        // First edge after reset release accepts a fresh request.
        run("restart", 8'd10, 8'd1, 8'd55, 1'b0, 23);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
